// File: rtl/fpnew_normalize_pipe.sv
// rtl/fpnew_normalize_pipe.sv - two-stage mantissa normalization ahead of FP rounding
//
// Turns an unnormalized wide mantissa plus a signed biased exponent into the packed
// {exp,mant} magnitude and the {round,sticky} pair. Normal, subnormal, zero and
// exponent-overflow results are all produced here, so the rounding unit can be
// purely combinational.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mantissa_i             value = mantissa_i / 2^(PRE_WIDTH-2), range [0,4)
//   exponent_i             signed biased exponent (EXP_BITS+2 bits)
//   sign_i, eff_sub_i      passed through to sign_o, eff_sub_o
//   tag_i                  opaque tag, passed through to tag_o
//   in_valid_i/in_ready_o  input handshake
//   flush_i                drop every in-flight operation
//   abs_value_o            {exp,mant} before rounding
//   round_sticky_bits_o    {R,S}
//   of_before_round_o      exponent overflowed before rounding
//   out_valid_o/out_ready_i output handshake
//   busy_o                 any stage holds a valid operation

module fpnew_normalize_pipe #(
  parameter int  EXP_BITS  = 8,
  parameter int  MAN_BITS  = 23,
  parameter int  PRE_WIDTH = 50,
  parameter type TagType   = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [PRE_WIDTH-1:0]         mantissa_i,
  input  logic signed [EXP_BITS+1:0]   exponent_i,
  input  logic                         sign_i,
  input  logic                         eff_sub_i,
  input  TagType                       tag_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         flush_i,
  output logic [EXP_BITS+MAN_BITS-1:0] abs_value_o,
  output logic [1:0]                   round_sticky_bits_o,
  output logic                         sign_o,
  output logic                         eff_sub_o,
  output TagType                       tag_o,
  output logic                         of_before_round_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  localparam int LZ_W = $clog2(PRE_WIDTH + 1);
  // One extra bit over the input exponent keeps exponent - lz + 1 free of wrap.
  localparam int EW   = EXP_BITS + 3;
  // Mantissa followed by room for the largest right shift, so nothing falls off.
  localparam int WW   = 2 * PRE_WIDTH + 2;

  localparam logic signed [EW-1:0] ONE     = EW'(1);
  localparam logic signed [EW-1:0] RSH_MAX = EW'(PRE_WIDTH + 1);
  localparam logic signed [EW-1:0] EXP_OVF = EW'((2 ** EXP_BITS) - 1);

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic s0_valid;
  logic s1_valid;
  logic s0_accept;
  logic s1_accept;
  logic s0_load;
  logic s1_load;

  assign s1_accept  = ~s1_valid | out_ready_i;
  assign s0_accept  = ~s0_valid | s1_accept;
  // During a flush everything offered is swallowed, so the input never stalls.
  assign in_ready_o = s0_accept | flush_i;
  assign s0_load    = in_valid_i & s0_accept & ~flush_i;
  assign s1_load    = s0_valid & s1_accept & ~flush_i;

  assign out_valid_o = s1_valid;
  assign busy_o      = s0_valid | s1_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else if (flush_i) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      if (s0_accept) s0_valid <= in_valid_i;
      if (s1_accept) s1_valid <= s0_valid;
    end
  end

  // ------------------------------------------------------------------
  // Stage 0: leading-zero count and operand capture
  // ------------------------------------------------------------------
  logic [LZ_W-1:0] lz;

  // Scan upward; the last hit is the most significant set bit.
  always_comb begin
    lz = LZ_W'(PRE_WIDTH);
    for (int i = 0; i < PRE_WIDTH; i++) begin
      if (mantissa_i[i]) lz = LZ_W'(PRE_WIDTH - 1 - i);
    end
  end

  logic [PRE_WIDTH-1:0]       s0_mant;
  logic signed [EXP_BITS+1:0] s0_exp;
  logic [LZ_W-1:0]            s0_lz;
  logic                       s0_zero;
  logic                       s0_sign;
  logic                       s0_eff_sub;
  TagType                     s0_tag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_mant    <= '0;
      s0_exp     <= '0;
      s0_lz      <= '0;
      s0_zero    <= 1'b0;
      s0_sign    <= 1'b0;
      s0_eff_sub <= 1'b0;
      s0_tag     <= '0;
    end else if (s0_load) begin
      s0_mant    <= mantissa_i;
      s0_exp     <= exponent_i;
      s0_lz      <= lz;
      s0_zero    <= (mantissa_i == '0);
      s0_sign    <= sign_i;
      s0_eff_sub <= eff_sub_i;
      s0_tag     <= tag_i;
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: exponent selection and normalizing shift
  // ------------------------------------------------------------------
  logic signed [EW-1:0] exp_ext;
  logic signed [EW-1:0] lz_ext;
  logic signed [EW-1:0] norm_exp;
  logic signed [EW-1:0] shamt;
  logic signed [EW-1:0] neg_shamt;
  logic [EW-1:0]        lsh;
  logic [EW-1:0]        rsh;
  logic                 is_normal;
  logic                 is_ovf;

  assign exp_ext   = EW'(s0_exp);
  assign lz_ext    = EW'(s0_lz);
  assign norm_exp  = exp_ext - lz_ext + ONE;
  assign is_normal = (norm_exp >= ONE);
  assign is_ovf    = (norm_exp >= EXP_OVF);

  // Positive = left shift. Normal results put the leading one on the implicit
  // bit (lz-1, which is a right shift by one when lz=0); subnormal results
  // align to the minimum exponent instead.
  assign shamt     = is_normal ? (lz_ext - ONE) : (exp_ext - ONE);
  assign neg_shamt = -shamt;
  assign lsh       = shamt;
  // Past PRE_WIDTH+1 every bit already lies below the round position.
  assign rsh       = (neg_shamt > RSH_MAX) ? RSH_MAX : neg_shamt;

  // A left shift never loses a set bit: in both paths the amount is below the
  // position of the leading one.
  logic [WW-1:0]        wide;
  logic [PRE_WIDTH-1:0] shifted;
  logic [PRE_WIDTH+1:0] lost;

  assign wide    = shamt[EW-1] ? ({s0_mant, {(PRE_WIDTH + 2){1'b0}}} >> rsh)
                               : ({s0_mant, {(PRE_WIDTH + 2){1'b0}}} << lsh);
  assign shifted = wide[WW-1 -: PRE_WIDTH];
  assign lost    = wide[PRE_WIDTH+1:0];

  // Bit PRE_WIDTH-2 is the implicit one; the stored fraction sits right below it.
  logic [MAN_BITS-1:0] mant_field;
  logic                round_bit;
  logic                sticky_bit;

  assign mant_field = shifted[PRE_WIDTH-3 -: MAN_BITS];
  assign round_bit  = shifted[PRE_WIDTH-3-MAN_BITS];
  assign sticky_bit = (|shifted[PRE_WIDTH-4-MAN_BITS:0]) | (|lost);

  // The top two bits of the shifted value and the upper exponent bits are only
  // range information; they are covered by is_normal / is_ovf.
  logic unused_bits;
  assign unused_bits = ^{shifted[PRE_WIDTH-1:PRE_WIDTH-2], norm_exp[EW-1:EXP_BITS]};

  logic [EXP_BITS+MAN_BITS-1:0] abs_d;
  logic [1:0]                   rs_d;
  logic                         of_d;

  always_comb begin
    abs_d = '0;
    rs_d  = 2'b00;
    of_d  = 1'b0;
    if (s0_zero) begin
      // exact zero: exponent is meaningless, result stays all zero
      abs_d = '0;
    end else if (is_ovf) begin
      // largest finite magnitude with R=S=1 lets the rounder choose inf or max-finite
      abs_d = {EXP_BITS'((2 ** EXP_BITS) - 2), {MAN_BITS{1'b1}}};
      rs_d  = 2'b11;
      of_d  = 1'b1;
    end else if (is_normal) begin
      abs_d = {norm_exp[EXP_BITS-1:0], mant_field};
      rs_d  = {round_bit, sticky_bit};
    end else begin
      abs_d = {{EXP_BITS{1'b0}}, mant_field};
      rs_d  = {round_bit, sticky_bit};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abs_value_o         <= '0;
      round_sticky_bits_o <= 2'b00;
      of_before_round_o   <= 1'b0;
      sign_o              <= 1'b0;
      eff_sub_o           <= 1'b0;
      tag_o               <= '0;
    end else if (s1_load) begin
      abs_value_o         <= abs_d;
      round_sticky_bits_o <= rs_d;
      of_before_round_o   <= of_d;
      sign_o              <= s0_sign;
      eff_sub_o           <= s0_eff_sub;
      tag_o               <= s0_tag;
    end
  end

endmodule
